center_of_mass: RTL and testbench

CENTER_OF_MASS -- requirements
Module: center_of_mass

---
 rtl/center_of_mass.sv | 147 ++++++++++++++
 tb/tb_center_of_mass.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/center_of_mass.sv
// Pixel centroid engine: accumulates pixel coordinates, then divides the sums by the
// pixel count with two parallel 32-cycle restoring dividers and publishes the result.
module center_of_mass (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        tabulate_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [31:0] sum_x_reg;
    logic [31:0] sum_y_reg;
    logic [19:0] count_reg;
    logic [5:0]  iter_reg;
    logic [31:0] divisor_reg;

    logic        accept;
    logic        iter_done;
    logic        publish;

    logic [1:0][31:0] dividend;
    logic [20:0]      quotient_low;

    assign accept    = (state_reg == IDLE) && tabulate_in && (count_reg != 20'd0);
    assign iter_done = (iter_reg == 6'd32);
    // One extra DIVIDE cycle after the 32nd quotient bit latches the outputs,
    // so valid_out coincides exactly with the DONE state.
    assign publish   = (state_reg == DIVIDE) && iter_done;
    assign dividend  = {sum_y_reg, sum_x_reg};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = DIVIDE;
            DIVIDE:  if (iter_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pixels are only taken in IDLE without a tabulate request; an accepted
    // request snapshots and clears the sums in the same edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sum_x_reg <= 32'd0;
            sum_y_reg <= 32'd0;
            count_reg <= 20'd0;
        end else if (state_reg == IDLE) begin
            if (accept) begin
                sum_x_reg <= 32'd0;
                sum_y_reg <= 32'd0;
                count_reg <= 20'd0;
            end else if (valid_in && !tabulate_in) begin
                sum_x_reg <= sum_x_reg + {21'd0, x_in};
                sum_y_reg <= sum_y_reg + {22'd0, y_in};
                count_reg <= count_reg + 20'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            iter_reg    <= 6'd0;
            divisor_reg <= 32'd0;
        end else if (accept) begin
            iter_reg    <= 6'd0;
            divisor_reg <= {12'd0, count_reg};
        end else if ((state_reg == DIVIDE) && !iter_done) begin
            iter_reg    <= iter_reg + 6'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [31:0] quo_reg;
            logic [31:0] rem_reg;
            logic [32:0] shifted;
            logic [32:0] trial;

            // Dividend bits shift out of the top of quo_reg into the remainder
            // while quotient bits shift in at the bottom.
            assign shifted = {rem_reg, quo_reg[31]};
            assign trial   = shifted - {1'b0, divisor_reg};

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    quo_reg <= 32'd0;
                    rem_reg <= 32'd0;
                end else if (accept) begin
                    quo_reg <= dividend[gi];
                    rem_reg <= 32'd0;
                end else if ((state_reg == DIVIDE) && !iter_done) begin
                    if (trial[32]) begin
                        rem_reg <= shifted[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b0};
                    end else begin
                        rem_reg <= trial[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b1};
                    end
                end
            end

            if (gi == 0) begin : g_x
                assign quotient_low[10:0] = quo_reg[10:0];
            end else begin : g_y
                assign quotient_low[20:11] = quo_reg[9:0];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_out     <= 11'd0;
            y_out     <= 10'd0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= publish;
            if (publish) begin
                x_out <= quotient_low[10:0];
                y_out <= quotient_low[20:11];
            end
        end
    end

endmodule

// File: tb/tb_center_of_mass.sv
// Directed and randomized frames for center_of_mass, checked against an arithmetic
// centroid model (sum / count, truncated) kept in the bench.
module tb_center_of_mass;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        tabulate_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    longint ref_sx = 0;
    longint ref_sy = 0;
    longint ref_cnt = 0;
    logic [10:0] last_x = '0;
    logic [9:0]  last_y = '0;

    center_of_mass dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .valid_in    (valid_in),
        .tabulate_in (tabulate_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .valid_out   (valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pixel(input int x, input int y, input bit v);
        x_in = 11'(x);
        y_in = 10'(y);
        valid_in = v;
        tabulate_in = 1'b0;
        @(negedge clk_in);
        if (v) begin
            ref_sx += longint'(x);
            ref_sy += longint'(y);
            ref_cnt += 1;
        end
        valid_in = 1'b0;
    endtask

    // Holds tabulate high for 'hold' cycles while spraying pixels that must all be dropped.
    task automatic do_tabulate(input string tag, input int hold);
        int pulses;
        int first_at;
        bit expect_pulse;
        logic [10:0] cx;
        logic [9:0]  cy;
        expect_pulse = (ref_cnt > 0);
        if (expect_pulse) begin
            last_x = 11'(ref_sx / ref_cnt);
            last_y = 10'(ref_sy / ref_cnt);
        end
        ref_sx = 0;
        ref_sy = 0;
        ref_cnt = 0;
        pulses = 0;
        first_at = 0;
        cx = x_out;
        cy = y_out;
        tabulate_in = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            valid_in = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            x_in = (k == 1) ? 11'h7ff : 11'($urandom_range(0, 2047));
            y_in = (k == 1) ? 10'h3ff : 10'($urandom_range(0, 1023));
            @(negedge clk_in);
            if (valid_out) begin
                pulses++;
                if (first_at == 0) first_at = k;
                cx = x_out;
                cy = y_out;
            end
        end
        tabulate_in = 1'b0;
        valid_in = 1'b0;
        check({tag, "_pulses"}, pulses, expect_pulse ? 1 : 0);
        if (expect_pulse) check({tag, "_latency"}, first_at, 34);
        check({tag, "_x"}, {21'd0, cx}, {21'd0, last_x});
        check({tag, "_y"}, {22'd0, cy}, {22'd0, last_y});
        $display("frame %s: pulses=%0d at=%0d x=%0d y=%0d (model x=%0d y=%0d)",
                 tag, pulses, first_at, cx, cy, last_x, last_y);
    endtask

    initial begin
        int pulses;
        int n;

        repeat (3) @(negedge clk_in);
        check("reset_x", {21'd0, x_out}, 32'd0);
        check("reset_y", {22'd0, y_out}, 32'd0);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 700; i++) pixel(i, 10, 1'b1);
        do_tabulate("ramp700", 500);

        for (int i = 0; i < 1024; i++) pixel(i, i / 5, 1'b1);
        do_tabulate("ramp1024", 60);

        do_tabulate("empty", 60);

        pixel(0, 0, 1'b1);
        do_tabulate("single_zero", 40);

        // Abort a division with reset ten cycles after acceptance.
        for (int i = 0; i < 20; i++) pixel(100 + i, 200, 1'b1);
        tabulate_in = 1'b1;
        repeat (10) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("abort_x", {21'd0, x_out}, 32'd0);
        check("abort_y", {22'd0, y_out}, 32'd0);
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        ref_sx = 0;
        ref_sy = 0;
        ref_cnt = 0;
        last_x = '0;
        last_y = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        tabulate_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk_in);
            if (valid_out) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        $display("abort: pulses after reset=%0d", pulses);

        for (int i = 0; i < 30; i++) pixel(i * 7, 1000 - i, 1'b1);
        do_tabulate("after_abort", 40);

        // Combined valid+tabulate pixel is (2047,1023) and must not bias the result.
        pixel(10, 20, 1'b1);
        pixel(30, 40, 1'b1);
        do_tabulate("both_high", 40);

        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 60);
            for (int i = 0; i < n; i++)
                pixel($urandom_range(0, 2047), $urandom_range(0, 1023), ($urandom_range(0, 3) != 0));
            pixel($urandom_range(0, 2047), $urandom_range(0, 1023), 1'b1);
            do_tabulate($sformatf("rand%0d", f), 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
